mv_trace_drain: RTL and testbench
=================================

Name: mv_trace_drain

Overview:
- Reader end of the debug trace path.
- Drains the 8-bit byte stream from the trace buffer's show-ahead read side and frames it into fixed-length packets on a valid/ready byte stream toward the host TX path.
- Also acts as the initiator of the trace-command handshake: it drives the req/cmd pair that arms the trace buffer's capture counter.
- Sits in the host/TX clock domain; this clock drives the buffer's read side.

Parameters:
- PAYLOAD_LEN, 64: payload bytes per packet; legal range 1..255.
- REQ_HOLD, 8: cycles trace_req is held high, and then held low, per command. Must be at least 4.
- FLUSH_TIMEOUT, 1024: idle cycles with the buffer empty mid-payload before padding starts.
- PAD_BYTE, 8'h00: filler byte used for a timeout flush.

Ports:
- wr_clock  in  1  block clock; also the trace buffer read clock.
- reset_n  in  1  asynchronous, active-low reset.
- buf_data  in  8  trace buffer head byte; valid whenever buf_empty=0.
- buf_empty  in  1  trace buffer read-side empty.
- buf_rd_en  out  1  read enable to the trace buffer. A byte is consumed on each edge where buf_rd_en=1 and buf_empty=0.
- tx_data  out  8  framed output byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  downstream accept.
- cmd_valid  in  1  one-cycle pulse requesting a trace command.
- cmd_in  in  8  trace count for the command; sampled when cmd_valid=1.
- trace_req  out  1  command request to the trace buffer.
- trace_cmd  out  8  command data to the trace buffer.
- cmd_busy  out  1  command handshake in progress; cmd_valid is ignored while high.
- seq_num  out  8  sequence number of the next packet.
- pkt_count  out  16  packets completed since reset; saturates at 16'hFFFF.

Behaviour:
- Reset values:
  - All outputs 0; seq_num=0.
  - FSM in IDLE; command FSM in CIDLE.
  - Reset mid-packet abandons the packet. No partial-packet completion after reset.
- Output register:
  - tx_data/tx_valid form a register. It may load when tx_valid=0 or tx_ready=1.
  - While tx_valid=1 and tx_ready=0, tx_data is held stable.
  - A byte transfers on an edge where tx_valid=1 and tx_ready=1.
- Frame format, in order:
  - 8'hA5, 8'h5A, seq_num, PAYLOAD_LEN[7:0], PAYLOAD_LEN payload bytes, then chk.
  - chk = XOR of seq, len and all payload bytes. The sync bytes are excluded from chk.
- Framer FSM:
  - IDLE -> SYNC0 when buf_empty=0. No buffer byte is consumed in IDLE.
  - SYNC0 -> SYNC1 -> SEQ -> LEN: each emits one byte per load opportunity. chk is cleared at SEQ entry and accumulates the SEQ and LEN bytes.
  - PAYLOAD:
    - buf_rd_en = (state==PAYLOAD) & (tx_valid=0 | tx_ready=1) & (payload_cnt < PAYLOAD_LEN). This path depends combinationally on tx_ready.
    - Each consumed buf_data is loaded into tx_data the same edge and XORed into chk; payload_cnt increments.
    - While buf_empty=1 and a load slot is free, idle_cnt increments; idle_cnt clears on any consumed byte.
    - When idle_cnt reaches FLUSH_TIMEOUT -> PAD.
  - PAD: emits PAD_BYTE (XORed into chk) until payload_cnt==PAYLOAD_LEN. No buffer reads occur in PAD.
  - When payload_cnt==PAYLOAD_LEN -> CHK. CHK emits chk, then -> IDLE on that byte's transfer.
  - On packet completion: seq_num+1, wrapping 8'hFF -> 8'h00; pkt_count+1, saturating.
- Throughput: with tx_ready held 1 and the buffer non-empty, there are no bubbles. The frame is PAYLOAD_LEN+5 consecutive bytes.
- Latency: the first tx_valid occurs 1 cycle after IDLE sees buf_empty=0.
- Command FSM:
  - CIDLE: on cmd_valid, latch cmd_in into trace_cmd, set trace_req=1 and cmd_busy=1 -> CHIGH.
  - CHIGH: after REQ_HOLD cycles, trace_req=0 -> CLOW.
  - CLOW: after REQ_HOLD cycles -> CIDLE, cmd_busy=0.
  - trace_cmd is stable from the req rise through the end of CLOW. The receiver latches on req high and commits on req low in its own clock domain.
  - cmd_valid while cmd_busy=1 is dropped; there is no queue.
- The command FSM and the framer are independent. A command during a packet does not disturb the framer.

Test Plan:
- Buffer preloaded with 64 bytes 0x00..0x3F, tx_ready=1 -> tx shows A5 5A 00 40 00..3F, then chk 0x40. Exactly 69 consecutive valid cycles; seq_num=1 afterwards.
- Same data with tx_ready toggling 1/0 every cycle -> identical byte sequence; tx_data is stable during every tx_ready=0 cycle; no byte is consumed twice or skipped.
- Buffer supplies only 10 bytes, then stays empty -> after 1024 idle cycles the remaining 54 bytes are 0x00; chk = XOR of seq, len and the 10 bytes.
- cmd_valid with cmd_in=0x05 -> trace_req high for 8 cycles then low for 8 cycles; trace_cmd=0x05 throughout; cmd_busy high for 16 cycles; a second cmd_valid at cycle 3 is ignored.
- 256 back-to-back packets -> seq wraps FF -> 00; pkt_count=256.
- reset_n asserted mid-PAYLOAD -> all outputs 0 on the next edge; after release, the first frame starts with A5 5A 00.

Source files
------------

// File: rtl/mv_trace_drain.sv
// rtl/mv_trace_drain.sv - trace buffer reader: frames drained bytes into packets and drives the trace-command handshake
module mv_trace_drain #(
  parameter int unsigned PAYLOAD_LEN   = 64,
  parameter int unsigned REQ_HOLD      = 8,
  parameter int unsigned FLUSH_TIMEOUT = 1024,
  parameter logic [7:0]  PAD_BYTE      = 8'h00
) (
  input  logic        wr_clock,
  input  logic        reset_n,
  input  logic [7:0]  buf_data,
  input  logic        buf_empty,
  output logic        buf_rd_en,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_in,
  output logic        trace_req,
  output logic [7:0]  trace_cmd,
  output logic        cmd_busy,
  output logic [7:0]  seq_num,
  output logic [15:0] pkt_count
);
  localparam int unsigned IW = $clog2(FLUSH_TIMEOUT + 1);
  localparam int unsigned CW = $clog2(REQ_HOLD + 1);
  localparam logic [7:0]    LEN8      = 8'(PAYLOAD_LEN);
  localparam logic [7:0]    LAST      = 8'(PAYLOAD_LEN - 1);
  localparam logic [IW-1:0] FT_LAST   = IW'(FLUSH_TIMEOUT - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(REQ_HOLD - 1);

  typedef enum logic [2:0] {IDLE, SYNC0, SYNC1, SEQ, LEN, PAYLOAD, PAD, CHK} state_t;
  typedef enum logic [1:0] {CIDLE, CHIGH, CLOW} cstate_t;

  state_t        state_q, state_d;
  cstate_t       cstate_q, cstate_d;
  logic [7:0]    payload_cnt, chk, load_byte;
  logic [IW-1:0] idle_cnt;
  logic [CW-1:0] ccnt, ccnt_d;
  logic          chk_sent, load_ok, load, consume, idle_tick, pkt_done, cmd_load;

  assign load_ok = ~tx_valid | tx_ready;

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    load_byte = 8'h00;
    buf_rd_en = 1'b0;
    consume   = 1'b0;
    idle_tick = 1'b0;
    pkt_done  = 1'b0;
    case (state_q)
      IDLE:  if (!buf_empty) state_d = SYNC0;
      SYNC0: if (load_ok) begin load = 1'b1; load_byte = 8'hA5;   state_d = SYNC1;   end
      SYNC1: if (load_ok) begin load = 1'b1; load_byte = 8'h5A;   state_d = SEQ;     end
      SEQ:   if (load_ok) begin load = 1'b1; load_byte = seq_num; state_d = LEN;     end
      LEN:   if (load_ok) begin load = 1'b1; load_byte = LEN8;    state_d = PAYLOAD; end
      PAYLOAD: begin
        buf_rd_en = load_ok & (payload_cnt < LEN8);
        if (buf_rd_en && !buf_empty) begin
          consume   = 1'b1;
          load      = 1'b1;
          load_byte = buf_data;
          if (payload_cnt == LAST) state_d = CHK;
        end else if (load_ok && buf_empty) begin
          idle_tick = 1'b1;
          if (idle_cnt == FT_LAST) state_d = PAD;
        end
      end
      PAD: if (load_ok) begin
        load      = 1'b1;
        load_byte = PAD_BYTE;
        if (payload_cnt == LAST) state_d = CHK;
      end
      CHK: begin
        // Load the checksum once, then leave only when it has actually been accepted.
        if (!chk_sent) begin
          if (load_ok) begin load = 1'b1; load_byte = chk; end
        end else if (tx_valid && tx_ready) begin
          pkt_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wr_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      tx_data     <= 8'h00;
      tx_valid    <= 1'b0;
      chk         <= 8'h00;
      payload_cnt <= 8'h00;
      idle_cnt    <= '0;
      chk_sent    <= 1'b0;
      seq_num     <= 8'h00;
      pkt_count   <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (load) begin
        tx_data  <= load_byte;
        tx_valid <= 1'b1;
      end else if (tx_ready) begin
        tx_valid <= 1'b0;
      end
      if (load && state_q == SEQ) chk <= load_byte;
      else if (load && state_q inside {LEN, PAYLOAD, PAD}) chk <= chk ^ load_byte;
      if (state_q == SEQ) payload_cnt <= 8'h00;
      else if (load && state_q inside {PAYLOAD, PAD}) payload_cnt <= payload_cnt + 8'd1;
      if (state_q == SEQ || consume) idle_cnt <= '0;
      else if (idle_tick) idle_cnt <= idle_cnt + IW'(1);
      if (pkt_done) chk_sent <= 1'b0;
      else if (load && state_q == CHK) chk_sent <= 1'b1;
      if (pkt_done) begin
        seq_num <= seq_num + 8'd1;
        if (pkt_count != 16'hFFFF) pkt_count <= pkt_count + 16'd1;
      end
    end
  end

  always_comb begin
    cstate_d  = cstate_q;
    ccnt_d    = ccnt;
    cmd_load  = 1'b0;
    trace_req = (cstate_q == CHIGH);
    cmd_busy  = (cstate_q != CIDLE);
    case (cstate_q)
      CIDLE: if (cmd_valid) begin
        cmd_load = 1'b1;
        ccnt_d   = '0;
        cstate_d = CHIGH;
      end
      CHIGH: if (ccnt == HOLD_LAST) begin ccnt_d = '0; cstate_d = CLOW; end
             else ccnt_d = ccnt + CW'(1);
      CLOW:  if (ccnt == HOLD_LAST) begin ccnt_d = '0; cstate_d = CIDLE; end
             else ccnt_d = ccnt + CW'(1);
      default: cstate_d = CIDLE;
    endcase
  end

  always_ff @(posedge wr_clock or negedge reset_n) begin
    if (!reset_n) begin
      cstate_q  <= CIDLE;
      ccnt      <= '0;
      trace_cmd <= 8'h00;
    end else begin
      cstate_q <= cstate_d;
      ccnt     <= ccnt_d;
      if (cmd_load) trace_cmd <= cmd_in;
    end
  end
endmodule

// File: tb/tb_mv_trace_drain.sv
// tb/tb_mv_trace_drain.sv - self-checking bench for mv_trace_drain
module tb_mv_trace_drain;
  localparam int         PLEN = 64;
  localparam logic [7:0] PAD  = 8'h00;

  logic        wr_clock = 1'b0;
  logic        reset_n;
  logic [7:0]  buf_data;
  logic        buf_empty;
  logic        buf_rd_en;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        cmd_valid;
  logic [7:0]  cmd_in;
  logic        trace_req;
  logic [7:0]  trace_cmd;
  logic        cmd_busy;
  logic [7:0]  seq_num;
  logic [15:0] pkt_count;

  always #5 wr_clock = ~wr_clock;

  mv_trace_drain #(.PAYLOAD_LEN(PLEN), .REQ_HOLD(8), .FLUSH_TIMEOUT(1024), .PAD_BYTE(PAD)) dut (
    .wr_clock(wr_clock), .reset_n(reset_n), .buf_data(buf_data), .buf_empty(buf_empty),
    .buf_rd_en(buf_rd_en), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cmd_valid(cmd_valid), .cmd_in(cmd_in), .trace_req(trace_req), .trace_cmd(trace_cmd),
    .cmd_busy(cmd_busy), .seq_num(seq_num), .pkt_count(pkt_count)
  );

  typedef struct {
    int          n;
    logic [7:0]  base;
    bit          toggle;
    logic [7:0]  chk;
    int          exp_run;
    logic [7:0]  seq_after;
    logic [15:0] cnt_after;
  } vec_t;

  vec_t       tbl [4];
  logic [7:0] buf_q [$];
  logic [7:0] exp_q [$];
  int         checks = 0, errors = 0;
  bit         toggle_mode = 1'b0, hold_pending = 1'b0;
  logic [7:0] held_data;
  int         run_len = 0, last_run = 0, tick_idx = 0, first_valid = -1;
  logic       s_req, s_busy;
  logic [7:0] s_cmd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic update_buf();
    buf_empty = (buf_q.size() == 0);
    if (buf_empty) buf_data = 8'h00;
    else buf_data = buf_q[0];
  endtask

  // One clock: sample and score at the falling edge, then model the buffer pop after the rising edge.
  task automatic tick();
    bit consumed;
    @(negedge wr_clock);
    if (hold_pending) begin
      check("hold_valid", tx_valid, 1);
      check("hold_data", tx_data, held_data);
    end
    hold_pending = tx_valid && !tx_ready;
    held_data    = tx_data;
    if (tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL tx_extra: got 0x%0h, expected no byte", tx_data);
      end else begin
        check("tx_byte", tx_data, exp_q.pop_front());
      end
    end
    if (tx_valid) run_len++;
    else begin
      if (run_len > 0) last_run = run_len;
      run_len = 0;
    end
    if (tx_valid && first_valid < 0) first_valid = tick_idx;
    tick_idx++;
    s_req = trace_req; s_busy = cmd_busy; s_cmd = trace_cmd;
    consumed = buf_rd_en && !buf_empty;
    @(posedge wr_clock);
    #1;
    if (consumed) void'(buf_q.pop_front());
    update_buf();
    tx_ready = toggle_mode ? ~tx_ready : 1'b1;
  endtask

  task automatic load_frame(input int n, input logic [7:0] base, input logic [7:0] seq, input logic [7:0] chk);
    logic [7:0] b;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(seq);
    exp_q.push_back(8'(PLEN));
    for (int i = 0; i < PLEN; i++) begin
      b = base + 8'(i);
      if (i < n) begin
        buf_q.push_back(b);
        exp_q.push_back(b);
      end else begin
        exp_q.push_back(PAD);
      end
    end
    exp_q.push_back(chk);
    update_buf();
  endtask

  task automatic drain(input string name, input int bound);
    int k = 0;
    first_valid = -1;
    tick_idx    = 0;
    while (exp_q.size() != 0 && k < bound) begin
      tick();
      k++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout: %0d bytes outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) tick();
  endtask

  task automatic check_idle(input string tag);
    check($sformatf("%s_tx_valid", tag), tx_valid, 0);
    check($sformatf("%s_tx_data", tag), tx_data, 0);
    check($sformatf("%s_buf_rd_en", tag), buf_rd_en, 0);
    check($sformatf("%s_trace_req", tag), trace_req, 0);
    check($sformatf("%s_trace_cmd", tag), trace_cmd, 0);
    check($sformatf("%s_cmd_busy", tag), cmd_busy, 0);
    check($sformatf("%s_seq_num", tag), seq_num, 0);
    check($sformatf("%s_pkt_count", tag), pkt_count, 0);
  endtask

  function automatic logic [7:0] calc_chk(input logic [7:0] seq, input logic [7:0] base);
    logic [7:0] c;
    c = seq ^ 8'(PLEN);
    for (int i = 0; i < PLEN; i++) c = c ^ (base + 8'(i));
    return c;
  endfunction

  initial begin
    reset_n = 1'b0; tx_ready = 1'b1; cmd_valid = 1'b0; cmd_in = 8'h00;
    buf_empty = 1'b1; buf_data = 8'h00;
    //            n   base   tgl chk    run seq    count
    tbl[0] = '{64, 8'h00, 1'b0, 8'h40, 69, 8'd1, 16'd1};
    tbl[1] = '{64, 8'h00, 1'b1, 8'h41, 0,  8'd2, 16'd2};
    tbl[2] = '{10, 8'h10, 1'b0, 8'h43, 0,  8'd3, 16'd3};
    tbl[3] = '{64, 8'h80, 1'b1, 8'h43, 0,  8'd4, 16'd4};

    repeat (3) @(posedge wr_clock);
    #1;
    check_idle("reset");
    reset_n = 1'b1;
    tick(); tick();
    check_idle("post_reset");

    for (int r = 0; r < 4; r++) begin
      toggle_mode = tbl[r].toggle;
      run_len = 0; last_run = 0;
      load_frame(tbl[r].n, tbl[r].base, 8'(r), tbl[r].chk);
      drain($sformatf("row%0d", r), 5000);
      check($sformatf("row%0d_latency", r), first_valid, 2);
      if (tbl[r].exp_run != 0) check($sformatf("row%0d_run", r), last_run, tbl[r].exp_run);
      check($sformatf("row%0d_seq_num", r), seq_num, tbl[r].seq_after);
      check($sformatf("row%0d_pkt_count", r), pkt_count, tbl[r].cnt_after);
      check($sformatf("row%0d_buf_left", r), buf_q.size(), 0);
    end
    toggle_mode = 1'b0;

    // Command handshake, with a second request mid-flight that must be dropped.
    cmd_in = 8'h05; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0; cmd_in = 8'h00;
    for (int k = 1; k <= 18; k++) begin
      if (k == 3) begin cmd_valid = 1'b1; cmd_in = 8'h77; end
      tick();
      cmd_valid = 1'b0;
      check($sformatf("cmd%0d_trace_req", k), s_req, (k <= 8));
      check($sformatf("cmd%0d_cmd_busy", k), s_busy, (k <= 16));
      if (k <= 16) check($sformatf("cmd%0d_trace_cmd", k), s_cmd, 8'h05);
    end

    // Reset in the middle of a payload abandons the packet.
    load_frame(64, 8'h00, 8'h04, 8'h44);
    for (int k = 0; k < 200 && exp_q.size() > 40; k++) tick();
    reset_n = 1'b0;
    #1;
    check_idle("midreset");
    exp_q.delete(); buf_q.delete(); update_buf(); hold_pending = 1'b0;
    tick();
    check_idle("midreset_edge");
    reset_n = 1'b1;
    tick();
    load_frame(64, 8'h20, 8'h00, 8'h40);
    drain("after_reset", 5000);
    check("after_reset_latency", first_valid, 2);
    check("after_reset_seq_num", seq_num, 1);
    check("after_reset_pkt_count", pkt_count, 1);

    // Back-to-back packets through the sequence-number wrap, with a command running alongside.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    for (int p = 0; p < 255; p++) load_frame(64, 8'(p * 3), 8'(p), calc_chk(8'(p), 8'(p * 3)));
    cmd_in = 8'h3C; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0; cmd_in = 8'h00;
    drain("wrap255", 25000);
    check("wrap255_seq_num", seq_num, 8'hFF);
    check("wrap255_pkt_count", pkt_count, 255);
    load_frame(64, 8'(255 * 3), 8'hFF, calc_chk(8'hFF, 8'(255 * 3)));
    drain("wrap256", 500);
    check("wrap256_seq_num", seq_num, 8'h00);
    check("wrap256_pkt_count", pkt_count, 256);
    check("wrap_trace_cmd", trace_cmd, 8'h3C);
    check("wrap_cmd_busy", cmd_busy, 0);
    check("wrap_buf_left", buf_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
